motor_ramp: RTL and testbench
=============================

# motor_ramp

Slew-rate limiter and direction interlock between the CPU-written motor command registers and one forward/backward pair of `pwm` instances. One instance per wheel. Accepts a target duty and direction, ramps the active PWM duty toward it in fixed steps on a prescaled tick, and performs direction reversal as ramp-down, then dead time, then ramp-up. The forward and backward duties are never non-zero at the same time.

## Interface

Parameters:
- `WIDTH`, 32: duty width; matches `pwm_in`.
- `STEP_DIV`, 16000: clocks per ramp tick (1 ms at 16 MHz); must be ≥ 1.
- `DEAD_TICKS`, 2000: dead-time length in clocks; must be ≥ 1.
- `MAX_DUTY`, 1000: upper clamp applied to commanded duty.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high. At top level it is driven from `!resetn`.
- `cmd_valid` input 1: one-cycle strobe; latches `cmd_dir`, `cmd_duty` and `cmd_step`.
- `cmd_dir` input 1: 0 = forward, 1 = backward.
- `cmd_duty` input WIDTH: target duty, unsigned.
- `cmd_step` input 16: duty change per tick; 0 = jump immediately.
- `estop` input 1: level, emergency stop.
- `duty_f` output WIDTH: to forward `pwm_in`.
- `duty_b` output WIDTH: to backward `pwm_in`.
- `cur_duty` output WIDTH: current ramp value, for bus readback.
- `state` output 2: 0 = RUN, 1 = BRAKE, 2 = DEAD.
- `busy` output 1: high when state ≠ RUN or current duty ≠ target.

## Operation

Registers:
- `cur` (WIDTH) and `cur_dir`: the duty and direction being driven now.
- `tgt` (WIDTH), `tgt_dir`, `step` (16): the latched command.
- `pre` (prescaler) and `dcnt` (dead-time counter).

Command latch:
- On `cmd_valid`: `tgt` ← min(`cmd_duty`, `MAX_DUTY`); `tgt_dir` ← `cmd_dir`; `step` ← `cmd_step`.
- A later command overwrites the previous one; the latest command wins. There is no queue and no backpressure.

Tick prescaler:
- `pre` is free-running 0 .. STEP_DIV−1.
- `tick` = (`pre` == STEP_DIV−1).
- Reset clears `pre`.

State machine:
- **RUN**
  - If `tgt_dir` ≠ `cur_dir`: go to BRAKE if `cur` ≠ 0; otherwise go to DEAD with `dcnt` ← DEAD_TICKS.
  - Else, if `step` == 0: `cur` ← `tgt` on every clock, without waiting for a tick.
  - Else, on `tick`:
    - `cur` < `tgt`: `cur` ← `cur`+`step`, saturating at `tgt`.
    - `cur` > `tgt`: `cur` ← `cur`−`step`, or `tgt` if (`cur`−`tgt`) ≤ `step`.
  - Arithmetic is done at WIDTH+1 bits, so it can neither wrap nor underflow.
- **BRAKE**
  - If `tgt_dir` == `cur_dir` (reversal aborted): return to RUN with no dead time. Ramping toward the new `tgt` continues from the present `cur`.
  - Else, ramp toward 0 using the same step rules (`step` == 0 gives `cur` ← 0 at once).
  - When `cur` == 0: go to DEAD with `dcnt` ← DEAD_TICKS.
- **DEAD**
  - `cur` is held at 0; `dcnt` decrements every clock.
  - When `dcnt` == 1: `cur_dir` ← `tgt_dir` and go to RUN.
  - Commands arriving during DEAD only update the target. The exit direction is the latest `tgt_dir`.
  - If the latest `tgt_dir` equals the old `cur_dir`, the block still completes DEAD and then ramps up in that direction.

Outputs (combinational from registers):
- `duty_f` = (`cur_dir` == 0 and state ≠ DEAD) ? `cur` : 0.
- `duty_b` = (`cur_dir` == 1 and state ≠ DEAD) ? `cur` : 0.

Emergency stop (`estop` high):
- Next edge: `cur` ← 0, `tgt` ← 0, state ← DEAD, `dcnt` ← DEAD_TICKS.
- `dcnt` is reloaded on every clock while `estop` is held.
- `cmd_valid` is ignored while `estop` is high.
- After release the block stays at 0 until a new command arrives.

## Timing

- Reset: `cur` = 0, `cur_dir` = 0, `tgt` = 0, `step` = 0, state = RUN, `dcnt` = 0.
- Output values after reset: `duty_f` = 0, `duty_b` = 0, `cur_duty` = 0, `state` = 0, `busy` = 0.
- Reset asserted mid-ramp or mid-DEAD zeroes both outputs after the next edge.
- Command latency: `cmd_valid` sampled at edge N updates `tgt` at edge N.
  - `step` == 0: `cur` (and the output) changes at edge N+1.
  - Otherwise: `cur` first changes on the first `tick` edge after N.
- `cmd_valid` and `tick` in the same cycle: that tick steps toward the old `tgt`. The new target applies from the following clock.
- Reversal at `cur` = C with `step` = S (S > 0):
  - ⌈C/S⌉ ticks of BRAKE;
  - then exactly DEAD_TICKS clocks with both outputs 0;
  - then RUN, ramping from 0.
- Both outputs non-zero in the same cycle is illegal in every state.
- `estop` beats `cmd_valid` and `tick`. `reset` beats everything.

## Test plan

Bench parameters: STEP_DIV = 4, DEAD_TICKS = 3, MAX_DUTY = 100.

1. Ramp up: cmd dir 0, duty 10, step 3 -> `duty_f` takes 3, 6, 9, 10 on successive ticks, 4 clocks apart; `duty_b` stays 0; `busy` falls on the edge where `duty_f` reaches 10.
2. Immediate: cmd dir 0, duty 50, step 0 -> `duty_f` = 50 one clock after the strobe; `busy` is 0 on the next cycle.
3. Reversal: from `duty_f` = 10, cmd dir 1, duty 6, step 4 -> `duty_f` takes 6, 2, 0 (`state` = 1); then 3 clocks with both outputs 0 (`state` = 2); then `duty_b` takes 4, 6. A monitor asserts the outputs are never both non-zero.
4. Aborted reversal: during BRAKE at `cur` = 6, cmd dir 0, duty 20, step 4 -> `state` = 0 the next clock with no dead time; `duty_f` takes 10, 14, 18, 20.
5. Clamp and saturation: cmd dir 0, duty 250, step 60 -> `duty_f` takes 60, 100 and holds at 100.
6. Estop: while `duty_f` = 40, assert `estop` and a `cmd_valid` (dir 1, duty 90) in the same cycle -> both outputs 0 the next clock, `state` = 2, `tgt` = 0; after release `duty_f` and `duty_b` remain 0; reset mid-ramp also gives all outputs 0.

Source files
------------

// File: rtl/motor_ramp.sv
// motor_ramp: per-wheel duty slew limiter with a brake/dead-time/ramp-up direction interlock
module motor_ramp #(
  parameter int WIDTH      = 32,
  parameter int STEP_DIV   = 16000,
  parameter int DEAD_TICKS = 2000,
  parameter int MAX_DUTY   = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_duty,
  input  logic [15:0]      cmd_step,
  input  logic             estop,
  output logic [WIDTH-1:0] duty_f,
  output logic [WIDTH-1:0] duty_b,
  output logic [WIDTH-1:0] cur_duty,
  output logic [1:0]       state,
  output logic             busy
);
  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int DW = $clog2(DEAD_TICKS + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(STEP_DIV - 1);
  localparam logic [DW-1:0] DEAD_LD = DW'(DEAD_TICKS);
  localparam logic [WIDTH-1:0] MAX_D = WIDTH'(MAX_DUTY);
  typedef enum logic [1:0] {RUN = 2'd0, BRAKE = 2'd1, DEAD = 2'd2} state_t;
  state_t r_state, w_nstate;
  logic [WIDTH-1:0] r_cur, r_tgt, w_ramp, w_cur_n, w_clamp;
  logic r_cur_dir, r_tgt_dir;
  logic [15:0] r_step;
  logic [PW-1:0] r_pre;
  logic [DW-1:0] r_dcnt, w_dcnt_n;
  logic w_tick, w_rev, w_adv, w_move, w_cmd;

  // one step from c toward t, computed one bit wider so it can neither wrap nor underflow
  function automatic logic [WIDTH-1:0] ramp_to(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] t,
                                               input logic [15:0] s);
    logic [WIDTH:0] cx, tx, sx;
    cx = {1'b0, c};
    tx = {1'b0, t};
    sx = (WIDTH+1)'(s);
    if (s == 16'd0) return t;
    if (c < t) return (cx + sx >= tx) ? t : WIDTH'(cx + sx);
    if (c > t) return (cx - tx <= sx) ? t : WIDTH'(cx - sx);
    return t;
  endfunction

  assign w_tick   = r_pre == PRE_MAX;
  assign w_rev    = r_tgt_dir != r_cur_dir;
  assign w_adv    = w_tick || r_step == 16'd0;
  assign w_cmd    = cmd_valid && !estop;
  assign w_clamp  = cmd_duty > MAX_D ? MAX_D : cmd_duty;
  assign w_ramp   = ramp_to(r_cur, r_state == BRAKE ? '0 : r_tgt, r_step);
  assign w_move   = w_adv && (r_state == RUN ? !w_rev : r_state == BRAKE && w_rev);
  assign w_cur_n  = estop || r_state == DEAD ? '0 : w_move ? w_ramp : r_cur;
  assign w_dcnt_n = estop || (w_nstate == DEAD && r_state != DEAD) ? DEAD_LD :
                    r_state == DEAD ? r_dcnt - DW'(1) : r_dcnt;

  always_ff @(posedge clk)
    if (reset) r_state <= RUN;
    else r_state <= w_nstate;

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      RUN:     w_nstate = !w_rev ? RUN : r_cur != '0 ? BRAKE : DEAD;
      BRAKE:   w_nstate = !w_rev ? RUN : r_cur == '0 ? DEAD : BRAKE;
      DEAD:    w_nstate = r_dcnt == DW'(1) ? RUN : DEAD;
      default: w_nstate = RUN;
    endcase
    if (estop) w_nstate = DEAD;
  end

  always_comb begin
    duty_f   = !r_cur_dir && r_state != DEAD ? r_cur : '0;
    duty_b   = r_cur_dir && r_state != DEAD ? r_cur : '0;
    cur_duty = r_cur;
    state    = r_state;
    busy     = r_state != RUN || r_cur != r_tgt;
  end

  always_ff @(posedge clk)
    if (reset) begin
      r_cur     <= '0;
      r_cur_dir <= 1'b0;
      r_tgt     <= '0;
      r_tgt_dir <= 1'b0;
      r_step    <= '0;
      r_pre     <= '0;
      r_dcnt    <= '0;
    end else begin
      r_pre     <= w_tick ? '0 : r_pre + PW'(1);
      r_cur     <= w_cur_n;
      r_dcnt    <= w_dcnt_n;
      r_cur_dir <= r_state == DEAD && w_nstate == RUN ? r_tgt_dir : r_cur_dir;
      r_tgt     <= estop ? '0 : w_cmd ? w_clamp : r_tgt;
      if (w_cmd) begin
        r_tgt_dir <= cmd_dir;
        r_step    <= cmd_step;
      end
    end
endmodule

// File: tb/tb_motor_ramp.sv
// tb_motor_ramp: cycle-exact vector table for motor_ramp with STEP_DIV=4, DEAD_TICKS=3, MAX_DUTY=100
module tb_motor_ramp;
  logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, cmd_dir = 1'b0, estop = 1'b0;
  logic [31:0] cmd_duty = '0;
  logic [15:0] cmd_step = '0;
  logic [31:0] duty_f, duty_b, cur_duty;
  logic [1:0] state;
  logic busy;
  int n_chk = 0, n_fail = 0;
  bit mon_on = 1'b0;

  typedef struct {
    int n;
    bit rst, v, dir, es, bz;
    logic [31:0] duty, f, b, c;
    logic [15:0] step;
    logic [1:0] st;
  } vec_t;
  vec_t tbl[$];

  motor_ramp #(.WIDTH(32), .STEP_DIV(4), .DEAD_TICKS(3), .MAX_DUTY(100)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir), .cmd_duty(cmd_duty),
    .cmd_step(cmd_step), .estop(estop), .duty_f(duty_f), .duty_b(duty_b), .cur_duty(cur_duty),
    .state(state), .busy(busy)
  );

  always #5 clk = ~clk;

  // interlock monitor: forward and backward must never be driven together
  always @(negedge clk)
    if (mon_on) begin
      n_chk++;
      if (duty_f != 0 && duty_b != 0) begin
        n_fail++;
        $display("FAIL interlock: duty_f=%0d duty_b=%0d both non-zero at %0t", duty_f, duty_b, $time);
      end
    end

  function automatic vec_t mk(int n, int rst, int v, int dir, int duty, int step, int es,
                              int f, int b, int c, int st, int bz);
    vec_t r;
    r.n = n; r.rst = rst != 0; r.v = v != 0; r.dir = dir != 0; r.es = es != 0; r.bz = bz != 0;
    r.duty = 32'(duty); r.step = 16'(step); r.f = 32'(f); r.b = 32'(b); r.c = 32'(c); r.st = 2'(st);
    return r;
  endfunction

  task automatic row(int n, int rst, int v, int dir, int duty, int step, int es,
                     int f, int b, int c, int st, int bz);
    tbl.push_back(mk(n, rst, v, dir, duty, step, es, f, b, c, st, bz));
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  // applies one record for r.n clocks (command strobe only in the first) and checks after each edge
  task automatic cyc(string nm, vec_t r);
    for (int i = 0; i < r.n; i++) begin
      @(negedge clk);
      reset = r.rst;
      cmd_valid = r.v && i == 0;
      cmd_dir = r.dir;
      cmd_duty = r.duty;
      cmd_step = r.step;
      estop = r.es;
      @(posedge clk);
      #1;
      chk($sformatf("%s.%0d duty_f", nm, i), duty_f, r.f);
      chk($sformatf("%s.%0d duty_b", nm, i), duty_b, r.b);
      chk($sformatf("%s.%0d cur_duty", nm, i), cur_duty, r.c);
      chk($sformatf("%s.%0d state", nm, i), 32'(state), 32'(r.st));
      chk($sformatf("%s.%0d busy", nm, i), 32'(busy), 32'(r.bz));
    end
  endtask

  initial begin
    //  n rst v dir duty step es   f   b   c  st bz
    row(2, 1, 0, 0,   0,  0, 0,   0,  0,  0, 0, 0);
    row(1, 0, 1, 0,  10,  3, 0,   0,  0,  0, 0, 1);
    row(2, 0, 0, 0,   0,  0, 0,   0,  0,  0, 0, 1);
    row(4, 0, 0, 0,   0,  0, 0,   3,  0,  3, 0, 1);
    row(4, 0, 0, 0,   0,  0, 0,   6,  0,  6, 0, 1);
    row(4, 0, 0, 0,   0,  0, 0,   9,  0,  9, 0, 1);
    row(1, 0, 0, 0,   0,  0, 0,  10,  0, 10, 0, 0);
    // reversal 10 forward -> 6 backward, step 4
    row(1, 0, 1, 1,   6,  4, 0,  10,  0, 10, 0, 1);
    row(2, 0, 0, 0,   0,  0, 0,  10,  0, 10, 1, 1);
    row(4, 0, 0, 0,   0,  0, 0,   6,  0,  6, 1, 1);
    row(4, 0, 0, 0,   0,  0, 0,   2,  0,  2, 1, 1);
    row(1, 0, 0, 0,   0,  0, 0,   0,  0,  0, 1, 1);
    row(3, 0, 0, 0,   0,  0, 0,   0,  0,  0, 2, 1);
    row(4, 0, 0, 0,   0,  0, 0,   0,  0,  0, 0, 1);
    row(4, 0, 0, 0,   0,  0, 0,   0,  4,  4, 0, 1);
    row(1, 0, 0, 0,   0,  0, 0,   0,  6,  6, 0, 0);
    // reset, immediate jump, then an aborted reversal at cur=6
    row(1, 1, 0, 0,   0,  0, 0,   0,  0,  0, 0, 0);
    row(1, 0, 1, 0,  10,  0, 0,   0,  0,  0, 0, 1);
    row(1, 0, 0, 0,   0,  0, 0,  10,  0, 10, 0, 0);
    row(1, 0, 1, 1,   6,  4, 0,  10,  0, 10, 0, 1);
    row(4, 0, 0, 0,   0,  0, 0,  10,  0, 10, 1, 1);
    row(1, 0, 0, 0,   0,  0, 0,   6,  0,  6, 1, 1);
    row(1, 0, 1, 0,  20,  4, 0,   6,  0,  6, 1, 1);
    row(2, 0, 0, 0,   0,  0, 0,   6,  0,  6, 0, 1);
    row(4, 0, 0, 0,   0,  0, 0,  10,  0, 10, 0, 1);
    row(4, 0, 0, 0,   0,  0, 0,  14,  0, 14, 0, 1);
    row(4, 0, 0, 0,   0,  0, 0,  18,  0, 18, 0, 1);
    row(1, 0, 0, 0,   0,  0, 0,  20,  0, 20, 0, 0);
    // clamp 250 -> 100 and saturation with step 60
    row(3, 0, 1, 0, 250, 60, 0,  20,  0, 20, 0, 1);
    row(4, 0, 0, 0,   0,  0, 0,  80,  0, 80, 0, 1);
    row(5, 0, 0, 0,   0,  0, 0, 100,  0,100, 0, 0);
    // estop at 40 with a simultaneous (ignored) backward command, held two clocks
    row(1, 0, 1, 0,  40,  0, 0, 100,  0,100, 0, 1);
    row(1, 0, 0, 0,   0,  0, 0,  40,  0, 40, 0, 0);
    row(2, 0, 1, 1,  90,  0, 1,   0,  0,  0, 2, 1);
    row(2, 0, 0, 0,   0,  0, 0,   0,  0,  0, 2, 1);
    row(2, 0, 0, 0,   0,  0, 0,   0,  0,  0, 0, 0);
    // reversal from standstill goes straight to dead time, then reset mid-ramp
    row(1, 0, 1, 1,  50,  5, 0,   0,  0,  0, 0, 1);
    row(3, 0, 0, 0,   0,  0, 0,   0,  0,  0, 2, 1);
    row(3, 0, 0, 0,   0,  0, 0,   0,  0,  0, 0, 1);
    row(4, 0, 0, 0,   0,  0, 0,   0,  5,  5, 0, 1);
    row(1, 0, 0, 0,   0,  0, 0,   0, 10, 10, 0, 1);
    row(1, 1, 0, 0,   0,  0, 0,   0,  0,  0, 0, 0);
    mon_on = 1'b1;
    foreach (tbl[i]) cyc($sformatf("row%0d", i), tbl[i]);
    // reset while in dead time
    cyc("dead_rst_a", mk(1, 0, 1, 1, 30, 0, 0, 0, 0, 0, 0, 1));
    cyc("dead_rst_b", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1));
    cyc("dead_rst_c", mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // step 0 jumps one clock after the strobe; full-scale command clamps to MAX_DUTY
    cyc("jump_a", mk(1, 0, 1, 0, 7, 0, 0, 0, 0, 0, 0, 1));
    cyc("jump_b", mk(1, 0, 0, 0, 0, 0, 0, 7, 0, 7, 0, 0));
    cyc("clamp_a", mk(1, 0, 1, 0, -1, 0, 0, 7, 0, 7, 0, 1));
    cyc("clamp_b", mk(1, 0, 0, 0, 0, 0, 0, 100, 0, 100, 0, 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
